// File: rtl/relu_stream.sv
// relu_stream: two-stage pipelined multi-lane activation unit (ReLU, leaky
// ReLU, clipped ReLU, bypass) with a valid/ready stream on both sides.
// S1 registers the incoming beat together with its mode and clip bound, and
// S2 registers the activated result, so changing mode or clip_max never
// affects a beat that is already in flight.
// Optional feature: define RELU_STATS_EN to add a saturating counter of
// negative input lanes (ports stats_clr / neg_cnt).

module relu_stream #(
  parameter int INPUT_WIDTH = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int LEAK_SHIFT  = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [1:0]                             mode,
  input  logic signed [DATA_WIDTH-1:0]           clip_max,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0] a_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0] a_out
`ifdef RELU_STATS_EN
  ,
  input  logic                                   stats_clr,
  output logic [31:0]                            neg_cnt
`endif
);

  localparam logic [1:0] MODE_RELU  = 2'b00;
  localparam logic [1:0] MODE_LEAKY = 2'b01;
  localparam logic [1:0] MODE_CLIP  = 2'b10;

  typedef logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0] lanes_t;

  // S1: captured input beat and the controls that travel with it
  logic                         s1_v_q, s1_v_d;
  lanes_t                       s1_data_q, s1_data_d;
  logic [1:0]                   s1_mode_q, s1_mode_d;
  logic signed [DATA_WIDTH-1:0] s1_clip_q, s1_clip_d;

  // S2: activated result presented downstream
  logic   s2_v_q, s2_v_d;
  lanes_t s2_data_q, s2_data_d;

  logic   s1_en;
  logic   s2_en;
  logic   in_fire;
  lanes_t act_res;

  // Single lane activation; a negative clip bound forces the whole clipped
  // range to zero rather than letting a non-negative x saturate to a negative value.
  function automatic logic [DATA_WIDTH-1:0] act_lane(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic [1:0]                   m,
    input logic signed [DATA_WIDTH-1:0] cmax
  );
    logic [DATA_WIDTH-1:0] r;
    r = x;
    case (m)
      MODE_RELU: begin
        r = x[DATA_WIDTH-1] ? '0 : x;
      end
      MODE_LEAKY: begin
        r = x[DATA_WIDTH-1] ? (x >>> LEAK_SHIFT) : x;
      end
      MODE_CLIP: begin
        if (cmax[DATA_WIDTH-1] || x[DATA_WIDTH-1]) begin
          r = '0;
        end else if (x > cmax) begin
          r = cmax;
        end else begin
          r = x;
        end
      end
      default: begin
        r = x;
      end
    endcase
    return r;
  endfunction

  // Stage enables: a stage advances when it is empty or its successor advances
  always_comb begin
    s2_en    = !s2_v_q || out_ready;
    s1_en    = !s1_v_q || s2_en;
    in_ready = s1_en;
    in_fire  = in_valid && in_ready;
  end

  // Activation of the beat held in S1, using the controls captured with it
  always_comb begin
    act_res = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      act_res[i] = act_lane(s1_data_q[i], s1_mode_q, s1_clip_q);
    end
  end

  // Next-state for both pipeline stages
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_mode_d = s1_mode_q;
    s1_clip_d = s1_clip_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    if (s1_en) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_data_d = a_in;
        s1_mode_d = mode;
        s1_clip_d = clip_max;
      end
    end
    if (s2_en) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d = act_res;
      end
    end
  end

  // Pipeline registers; reset discards any in-flight beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_mode_q <= '0;
      s1_clip_q <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_mode_q <= s1_mode_d;
      s1_clip_q <= s1_clip_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
    end
  end

  assign out_valid = s2_v_q;
  assign a_out     = s2_data_q;

`ifdef RELU_STATS_EN
  localparam int NEG_W = $clog2(INPUT_WIDTH + 1);

  logic [NEG_W-1:0] neg_lanes;
  logic [32:0]      neg_sum;
  logic [31:0]      neg_cnt_q, neg_cnt_d;

  // Number of negative lanes in the current input beat
  always_comb begin
    neg_lanes = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      neg_lanes = neg_lanes + NEG_W'(a_in[i][DATA_WIDTH-1]);
    end
  end

  // Saturating accumulate on accepted beats; clear wins over an increment
  always_comb begin
    neg_sum   = {1'b0, neg_cnt_q} + 33'(neg_lanes);
    neg_cnt_d = neg_cnt_q;
    if (stats_clr) begin
      neg_cnt_d = '0;
    end else if (in_fire) begin
      neg_cnt_d = neg_sum[32] ? '1 : neg_sum[31:0];
    end
  end

  // Negative-lane counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_cnt_q <= '0;
    end else begin
      neg_cnt_q <= neg_cnt_d;
    end
  end

  assign neg_cnt = neg_cnt_q;
`endif

endmodule

// File: tb/tb_relu_stream.sv
// Self-checking bench for relu_stream: directed scenarios plus randomized
// traffic, checked against a queue-based reference model of the activation.

module tb_relu_stream;

  localparam int IW = 3;
  localparam int DW = 16;
  localparam int LS = 3;

  typedef logic [IW-1:0][DW-1:0] beat_t;
  typedef struct {
    beat_t d;
    int    cyc;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           mode;
  logic signed [DW-1:0] clip_max;
  logic                 in_valid;
  logic                 in_ready;
  beat_t                a_in;
  logic                 out_valid;
  logic                 out_ready;
  beat_t                a_out;
`ifdef RELU_STATS_EN
  logic                 stats_clr;
  logic [31:0]          neg_cnt;
  longint               neg_model;
`endif

  relu_stream #(.INPUT_WIDTH(IW), .DATA_WIDTH(DW), .LEAK_SHIFT(LS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .clip_max (clip_max),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .a_out    (a_out)
`ifdef RELU_STATS_EN
    ,
    .stats_clr(stats_clr),
    .neg_cnt  (neg_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;
  bit    chk_lat = 0;
  bit    hold_prev = 0;
  beat_t held_data;
  exp_t  exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: lane-by-lane activation in plain integer arithmetic
  function automatic beat_t ref_act(input beat_t a, input logic [1:0] m, input logic signed [DW-1:0] cm);
    beat_t r;
    int x, y, c;
    c = cm;
    for (int i = 0; i < IW; i++) begin
      x = $signed(a[i]);
      case (m)
        2'd0: y = (x < 0) ? 0 : x;
        2'd1: y = (x < 0) ? ((x - (2**LS - 1)) / (2**LS)) : x;  // floor division
        2'd2: y = (c < 0 || x < 0) ? 0 : ((x > c) ? c : x);
        default: y = x;
      endcase
      r[i] = y[DW-1:0];
    end
    return r;
  endfunction

  function automatic int count_neg(input beat_t a);
    int n = 0;
    for (int i = 0; i < IW; i++) if ($signed(a[i]) < 0) n++;
    return n;
  endfunction

  // One clock: observe at negedge, update model, then move to posedge+1
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    cyc++;
    acc = in_valid && in_ready;
    if (hold_prev) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(a_out), 64'(held_data));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(a_out), 64'hDEAD_0000_0000);
      end else begin
        e = exp_q.pop_front();
        check("data", 64'(a_out), 64'(e.d));
        if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
    hold_prev = out_valid && !out_ready;
    held_data = a_out;
    if (acc) begin
      e.d = ref_act(a_in, mode, clip_max);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
`ifdef RELU_STATS_EN
    check("neg_cnt", 64'(neg_cnt), 64'(neg_model));
    if (stats_clr) neg_model = 0;
    else if (acc) begin
      neg_model += count_neg(a_in);
      if (neg_model > 64'hFFFF_FFFF) neg_model = 64'hFFFF_FFFF;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic signed [DW-1:0] cm,
                      input int l0, input int l1, input int l2);
    bit acc;
    int k;
    mode = m;
    clip_max = cm;
    a_in[0] = l0[DW-1:0];
    a_in[1] = l1[DW-1:0];
    a_in[2] = l2[DW-1:0];
    in_valid = 1'b1;
    k = 0;
    do begin
      step(acc);
      k++;
    end while (!acc && k < 50);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit acc;
    in_valid = 1'b0;
    for (int k = 0; k < budget && exp_q.size() != 0; k++) step(acc);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [DW-1:0] rand_lane();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      4: return 16'($signed($urandom_range(0, 64)) - 32);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bit acc;
    int idx;
    beat_t bp_beats[4];

    rst_n = 1'b0;
    mode = 2'd0;
    clip_max = '0;
    in_valid = 1'b0;
    a_in = '0;
    out_ready = 1'b1;
`ifdef RELU_STATS_EN
    stats_clr = 1'b0;
    neg_model = 0;
`endif

    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_a_out", 64'(a_out), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef RELU_STATS_EN
    check("rst_neg_cnt", 64'(neg_cnt), 64'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ReLU, full throughput, fixed latency, in_ready always high
    chk_lat = 1;
    check("relu_in_ready0", 64'(in_ready), 64'd1);
    send(2'd0, 16'sd0, 10, 25, 50);
    check("relu_in_ready1", 64'(in_ready), 64'd1);
    send(2'd0, 16'sd0, -10, -25, -50);
    check("relu_in_ready2", 64'(in_ready), 64'd1);
    send(2'd0, 16'sd0, -100, 0, 100);
    check("relu_in_ready3", 64'(in_ready), 64'd1);
    drain(10);

    // leaky: floor shift including the most negative value
    send(2'd1, 16'sd0, -10, -1, -32768);
    send(2'd1, 16'sd0, 7, 0, 32767);
    drain(10);

    // clipped, then a negative clip bound on the following beat
    send(2'd2, 16'sd20, 15, -20, 30);
    send(2'd2, -16'sd5, 5, 5, 5);
    send(2'd3, 16'sd0, -7, 32767, -32768);
    drain(10);
    chk_lat = 0;

    // Backpressure: 5 stalled clocks with 4 beats waiting
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < IW; j++) bp_beats[i][j] = 16'(1000 * (i + 1) + j - 1500);
    mode = 2'd0;
    clip_max = '0;
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      a_in = bp_beats[idx];
      in_valid = 1'b1;
      step(acc);
      if (acc) idx++;
      if (k >= 2) check("bp_stall_accept", 64'(acc), 64'd0);
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_head", 64'(a_out), 64'(ref_act(bp_beats[0], 2'd0, '0)));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_stream_valid", 64'(out_valid), 64'd1);
      if (idx < 4) begin
        a_in = bp_beats[idx];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step(acc);
      if (acc) idx++;
    end
    check("bp_all_sent", 64'(idx), 64'd4);
    drain(10);

    // Reset with two beats in flight
    send(2'd3, 16'sd0, 1, 2, 3);
    send(2'd3, 16'sd0, 4, 5, 6);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_a_out", 64'(a_out), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    hold_prev = 0;
`ifdef RELU_STATS_EN
    neg_model = 0;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(acc);
      check("post_rst_idle", 64'(out_valid), 64'd0);
    end

`ifdef RELU_STATS_EN
    stats_clr = 1'b1;
    step(acc);
    stats_clr = 1'b0;
    send(2'd0, 16'sd0, -1, 2, -3);
    send(2'd0, 16'sd0, -4, -5, -6);
    drain(10);
    check("stats_five", 64'(neg_cnt), 64'd5);
    stats_clr = 1'b1;
    send(2'd0, 16'sd0, -7, -8, -9);
    stats_clr = 1'b0;
    check("stats_clr_win", 64'(neg_cnt), 64'd0);
    drain(10);
`endif

    // Randomized traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      mode = 2'($urandom_range(0, 3));
      clip_max = ($urandom_range(0, 3) == 0) ? 16'($signed($urandom_range(0, 20)) - 10) : rand_lane();
      for (int j = 0; j < IW; j++) a_in[j] = rand_lane();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef RELU_STATS_EN
      stats_clr = ($urandom_range(0, 30) == 0);
`endif
      step(acc);
    end
`ifdef RELU_STATS_EN
    stats_clr = 1'b0;
`endif
    out_ready = 1'b1;
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
